lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 149 ++++++++++++++
 tb/tb_lsu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one core access in, byte-accurate RAM word accesses out, unaligned accesses split in two.
// Latency: load 3 or 4 cycles, store 2 or 3, illegal 1. clk_en low stalls and masks strobes; i_req is taken only in IDLE.
module lsu #(
    parameter int ADDR_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_rdata,
    output logic [ADDR_WIDTH:0]   o_ram_addr,
    output logic                  o_ram_re,
    input  logic [31:0]           i_ram_rdata,
    output logic                  o_ram_we,
    output logic [3:0]            o_ram_be,
    output logic [31:0]           o_ram_wdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_LD0, S_LD1, S_LDW, S_ST0, S_ST1, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, lo_q, rdata_q;
    logic        err_q;

    logic [1:0]  off;
    logic [29:0] word_q, word_nxt, ram_word;
    logic [2:0]  size;
    logic [3:0]  mask;
    logic        split, legal;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide, ld_pair;
    logic [31:0] ld_shift, ld_res;

    assign off      = addr_q[1:0];
    assign word_q   = addr_q[31:2];
    assign word_nxt = word_q + 30'd1;
    assign legal    = i_we ? (i_funct3 <= 3'd2)
                           : ((i_funct3 != 3'd3) && (i_funct3 < 3'd6));

    always_comb begin
        size = 3'd4;
        mask = 4'b1111;
        case (f3_q[1:0])
            2'd0: begin size = 3'd1; mask = 4'b0001; end
            2'd1: begin size = 3'd2; mask = 4'b0011; end
            default: ;
        endcase
    end

    assign split = ({1'b0, off} + size) > 3'd4;

    // Low half feeds the first word, high half spills into the next word of a split store.
    assign be_wide = {4'b0000, mask} << off;
    assign wd_wide = {32'd0, wdata_q} << {off, 3'b000};

    assign ld_pair  = split ? {i_ram_rdata, lo_q} : {32'd0, i_ram_rdata};
    assign ld_shift = 32'(ld_pair >> {off, 3'b000});

    always_comb begin
        case (f3_q)
            3'd0:    ld_res = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_res = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_res = {24'd0, ld_shift[7:0]};
            3'd5:    ld_res = {16'd0, ld_shift[15:0]};
            default: ld_res = ld_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        o_ram_re    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_be    = 4'b0000;
        o_ram_wdata = 32'd0;
        ram_word    = 30'd0;
        case (state_q)
            S_IDLE: if (i_req) state_d = !legal ? S_DONE : (i_we ? S_ST0 : S_LD0);
            S_LD0: begin
                o_ram_re = 1'b1;
                ram_word = word_q;
                state_d  = split ? S_LD1 : S_LDW;
            end
            S_LD1: begin
                o_ram_re = 1'b1;
                ram_word = word_nxt;
                state_d  = S_LDW;
            end
            S_LDW: state_d = S_DONE;
            S_ST0: begin
                o_ram_we    = 1'b1;
                o_ram_be    = be_wide[3:0];
                o_ram_wdata = wd_wide[31:0];
                ram_word    = word_q;
                state_d     = split ? S_ST1 : S_DONE;
            end
            S_ST1: begin
                o_ram_we    = 1'b1;
                o_ram_be    = be_wide[7:4];
                o_ram_wdata = wd_wide[63:32];
                ram_word    = word_nxt;
                state_d     = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!clk_en) begin
            o_ram_re = 1'b0;
            o_ram_we = 1'b0;
        end
    end

    assign o_ram_addr = (ADDR_WIDTH + 1)'(ram_word);
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE) && clk_en;
    assign o_err      = err_q && (state_q == S_DONE);
    assign o_rdata    = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            lo_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_req) begin
                f3_q    <= i_funct3;
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                err_q   <= !legal;
                if (!legal) rdata_q <= 32'd0;
            end
            if (state_q == S_LD1) lo_q <= i_ram_rdata;
            if (state_q == S_LDW) rdata_q <= ld_res;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: RAM model with one-cycle read latency, strobe logs, immediate-assertion checks.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst, clk_en, i_req, i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_busy, o_done, o_err;
    logic [31:0] o_rdata;
    logic [31:0] o_ram_addr;
    logic        o_ram_re, o_ram_we;
    logic [31:0] i_ram_rdata;
    logic [3:0]  o_ram_be;
    logic [31:0] o_ram_wdata;

    logic [31:0] mem [0:255];
    logic [31:0] re_log [0:63];
    logic [31:0] wa_log [0:63];
    logic [3:0]  wb_log [0:63];
    logic [31:0] wd_log [0:63];
    int re_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int errors = 0, checks = 0;
    int lat, re0, wr0, dn0;

    always #5 clk = ~clk;

    lsu #(.ADDR_WIDTH(31)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_ram_addr(o_ram_addr), .o_ram_re(o_ram_re), .i_ram_rdata(i_ram_rdata),
        .o_ram_we(o_ram_we), .o_ram_be(o_ram_be), .o_ram_wdata(o_ram_wdata)
    );

    always @(posedge clk) begin
        if (clk_en && o_ram_re) begin
            i_ram_rdata <= mem[o_ram_addr[7:0]];
            re_log[re_cnt % 64] = o_ram_addr;
            re_cnt++;
        end
        if (clk_en && o_ram_we) begin
            wa_log[wr_cnt % 64] = o_ram_addr;
            wb_log[wr_cnt % 64] = o_ram_be;
            wd_log[wr_cnt % 64] = o_ram_wdata;
            wr_cnt++;
        end
        if (o_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int cyc);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
        tick();
        i_req = 1'b0;
        cyc = 1;
        while (!o_done && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; i_req = 1'b0; i_we = 1'b0;
        i_funct3 = 3'd0; i_addr = 32'd0; i_wdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        tick(); tick();
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_strobes", {o_ram_re, o_ram_we, o_ram_be}, 32'd0);
        rst = 1'b0;
        tick();

        // LW aligned
        mem[8'h40] = 32'hDEADBEEF;
        re0 = re_cnt;
        access(1'b0, 3'd2, 32'h0000_0100, 32'd0, lat);
        check("lw_lat", lat, 3);
        check("lw_rdata", o_rdata, 32'hDEADBEEF);
        check("lw_err", {31'd0, o_err}, 32'd0);
        check("lw_re_cnt", re_cnt - re0, 1);
        check("lw_re_addr", re_log[re0 % 64], 32'h40);
        tick(); tick();
        check("rdata_hold", o_rdata, 32'hDEADBEEF);
        check("idle_busy", {31'd0, o_busy}, 32'd0);

        // LH / LHU split across words
        mem[8'h40] = 32'h80123456;
        mem[8'h41] = 32'hABCDEF12;
        re0 = re_cnt;
        access(1'b0, 3'd1, 32'h0000_0103, 32'd0, lat);
        check("lh_lat", lat, 4);
        check("lh_rdata", o_rdata, 32'h00001280);
        check("lh_re0", re_log[re0 % 64], 32'h40);
        check("lh_re1", re_log[(re0 + 1) % 64], 32'h41);
        tick();
        access(1'b0, 3'd5, 32'h0000_0103, 32'd0, lat);
        check("lhu_rdata", o_rdata, 32'h00001280);
        tick();

        // LB / LBU sign handling
        mem[8'h40] = 32'h00F00000;
        access(1'b0, 3'd0, 32'h0000_0102, 32'd0, lat);
        check("lb_lat", lat, 3);
        check("lb_rdata", o_rdata, 32'hFFFFFFF0);
        tick();
        access(1'b0, 3'd4, 32'h0000_0102, 32'd0, lat);
        check("lbu_rdata", o_rdata, 32'h000000F0);
        tick();

        // SW split
        wr0 = wr_cnt;
        access(1'b1, 3'd2, 32'h0000_0201, 32'hAABBCCDD, lat);
        check("sw_lat", lat, 3);
        check("sw_err", {31'd0, o_err}, 32'd0);
        check("sw_wr_cnt", wr_cnt - wr0, 2);
        check("sw_a0", wa_log[wr0 % 64], 32'h80);
        check("sw_be0", {28'd0, wb_log[wr0 % 64]}, 32'hE);
        check("sw_d0", wd_log[wr0 % 64], 32'hBBCCDD00);
        check("sw_a1", wa_log[(wr0 + 1) % 64], 32'h81);
        check("sw_be1", {28'd0, wb_log[(wr0 + 1) % 64]}, 32'h1);
        check("sw_d1", wd_log[(wr0 + 1) % 64], 32'h000000AA);
        tick();

        // SH aligned in upper half
        wr0 = wr_cnt;
        access(1'b1, 3'd1, 32'h0000_0202, 32'h0000BEEF, lat);
        check("sh_lat", lat, 2);
        check("sh_be", {28'd0, wb_log[wr0 % 64]}, 32'hC);
        check("sh_d", wd_log[wr0 % 64], 32'hBEEF0000);
        tick();

        // Illegal codes
        re0 = re_cnt; wr0 = wr_cnt;
        access(1'b0, 3'd3, 32'h0000_0100, 32'd0, lat);
        check("ill_ld_lat", lat, 1);
        check("ill_ld_err", {31'd0, o_err}, 32'd1);
        check("ill_ld_rdata", o_rdata, 32'd0);
        tick();
        access(1'b1, 3'd4, 32'h0000_0100, 32'h12345678, lat);
        check("ill_st_lat", lat, 1);
        check("ill_st_err", {31'd0, o_err}, 32'd1);
        check("ill_no_strobe", (re_cnt - re0) + (wr_cnt - wr0), 0);
        tick();

        // LW wrapping past the top of memory
        mem[8'hFF] = 32'h11223344;
        mem[8'h00] = 32'h55667788;
        re0 = re_cnt;
        access(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, lat);
        check("wrap_lat", lat, 4);
        check("wrap_re0", re_log[re0 % 64], 32'h3FFFFFFF);
        check("wrap_re1", re_log[(re0 + 1) % 64], 32'h0);
        check("wrap_rdata", o_rdata, 32'h77881122);
        tick();

        // Reset while in LD1
        re0 = re_cnt; dn0 = done_cnt;
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'd1; i_addr = 32'h0000_0103;
        tick();
        i_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        tick(); tick(); tick();
        check("rst_mid_done", done_cnt - dn0, 0);
        check("rst_mid_re", re_cnt - re0, 2);

        // clk_en freeze during store
        wr0 = wr_cnt;
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'd2; i_addr = 32'h0000_0300; i_wdata = 32'h12345678;
        tick();
        i_req = 1'b0;
        clk_en = 1'b0;
        #1;
        check("cke_we_masked", {31'd0, o_ram_we}, 32'd0);
        tick(); tick();
        check("cke_busy", {31'd0, o_busy}, 32'd1);
        clk_en = 1'b1;
        tick();
        check("cke_done", {31'd0, o_done}, 32'd1);
        tick();
        check("cke_wr_cnt", wr_cnt - wr0, 1);
        check("cke_addr", wa_log[wr0 % 64], 32'hC0);
        check("cke_data", wd_log[wr0 % 64], 32'h12345678);

        // Request pulses while busy are ignored
        wr0 = wr_cnt;
        mem[8'h40] = 32'hCAFEF00D;
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h0000_0100;
        tick();
        i_we = 1'b1; i_addr = 32'h0000_0104; i_wdata = 32'h99999999;
        tick();
        i_req = 1'b0;
        tick();
        check("busy_req_done", {31'd0, o_done}, 32'd1);
        check("busy_req_rdata", o_rdata, 32'hCAFEF00D);
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
        check("busy_req_idle", {31'd0, o_busy}, 32'd0);
        tick();
        check("busy_req_idle2", {31'd0, o_busy}, 32'd0);
        check("busy_req_nowr", wr_cnt - wr0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
